// File: rtl/ram_write_arbiter_8.sv
// ram_write_arbiter_8
// Write-side front end for the shared 8-read-port RAM. Each producer port owns
// one holding slot. Held slots are drained round-robin, one per cycle, onto the
// RAM's registered write port.
module ram_write_arbiter_8 #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int NUM_PORTS  = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             req_valid_i,
   output logic [NUM_PORTS-1:0]             req_ready_o,
   input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  req_addr_i,
   input  logic [DATA_WIDTH*NUM_PORTS-1:0]  req_data_i,
   output logic                             write_en_o,
   output logic [ADDR_WIDTH-1:0]            write_addr_o,
   output logic [DATA_WIDTH-1:0]            data_o,
   output logic [$clog2(NUM_PORTS+1)-1:0]   pending_o,
   output logic                             idle_o
);

   localparam int PTR_W  = $clog2(NUM_PORTS);
   localparam int CAND_W = PTR_W + 1;
   localparam int CNT_W  = $clog2(NUM_PORTS+1);

   // Per-slot state, flattened so the arbiter and output mux can index it.
   logic [NUM_PORTS-1:0]             held_vec;
   logic [NUM_PORTS-1:0]             held_next_vec;
   logic [ADDR_WIDTH*NUM_PORTS-1:0]  slot_addr;
   logic [DATA_WIDTH*NUM_PORTS-1:0]  slot_data;

   // Arbitration result for the current cycle.
   logic [NUM_PORTS-1:0] grant;
   logic                 grant_valid;
   logic [PTR_W-1:0]     grant_idx;
   logic [CAND_W-1:0]    cand;

   // Round-robin pointer and registered write port.
   logic [PTR_W-1:0]      rr_ptr_q,     rr_ptr_d;
   logic                  write_en_q,   write_en_d;
   logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
   logic [DATA_WIDTH-1:0] wdata_q,      wdata_d;
   logic [CNT_W-1:0]      pending_q,    pending_d;

   // A slot can accept when empty, or when it is being drained this same edge.
   assign req_ready_o = ~held_vec | grant;

   // One holding slot per producer port.
   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_slot
         logic                  held_q, held_d;
         logic [ADDR_WIDTH-1:0] addr_q, addr_d;
         logic [DATA_WIDTH-1:0] data_q, data_d;
         logic                  accept;

         assign accept = req_valid_i[gi] & req_ready_o[gi];

         // Slot next state: drain on grant, refill on accept (accept wins).
         always_comb begin
            held_d = held_q & ~grant[gi];
            addr_d = addr_q;
            data_d = data_q;
            if (accept) begin
               held_d = 1'b1;
               addr_d = req_addr_i[ADDR_WIDTH*gi +: ADDR_WIDTH];
               data_d = req_data_i[DATA_WIDTH*gi +: DATA_WIDTH];
            end
         end

         // Slot registers.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               held_q <= 1'b0;
               addr_q <= '0;
               data_q <= '0;
            end else begin
               held_q <= held_d;
               addr_q <= addr_d;
               data_q <= data_d;
            end
         end

         assign held_vec[gi]                             = held_q;
         assign held_next_vec[gi]                        = held_d;
         assign slot_addr[ADDR_WIDTH*gi +: ADDR_WIDTH]   = addr_q;
         assign slot_data[DATA_WIDTH*gi +: DATA_WIDTH]   = data_q;
      end
   endgenerate

   // Round-robin search: first held slot at or after rr_ptr, wrapping.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int off = 0; off < NUM_PORTS; off++) begin
         cand = {1'b0, rr_ptr_q} + CAND_W'(off);
         if (cand >= CAND_W'(NUM_PORTS)) begin
            cand = cand - CAND_W'(NUM_PORTS);
         end
         if (!grant_valid && held_vec[cand[PTR_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[PTR_W-1:0];
         end
      end
   end

   // One-hot form of the grant, consumed by the slots and ready logic.
   always_comb begin
      grant = '0;
      if (grant_valid) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // Write-port, pointer and occupancy next state.
   always_comb begin
      write_en_d   = grant_valid;
      write_addr_d = write_addr_q;
      wdata_d      = wdata_q;
      rr_ptr_d     = rr_ptr_q;
      pending_d    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            write_addr_d = slot_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
            wdata_d      = slot_data[DATA_WIDTH*i +: DATA_WIDTH];
         end
         pending_d = pending_d + CNT_W'(held_next_vec[i]);
      end
      if (grant_valid) begin
         // Pointer moves just past the winner so it becomes lowest priority.
         if (grant_idx == PTR_W'(NUM_PORTS-1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
         end
      end
   end

   // Write-port, pointer and occupancy registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         wdata_q      <= '0;
         pending_q    <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         wdata_q      <= wdata_d;
         pending_q    <= pending_d;
      end
   end

   assign write_en_o   = write_en_q;
   assign write_addr_o = write_addr_q;
   assign data_o       = wdata_q;
   assign pending_o    = pending_q;
   assign idle_o       = (pending_q == '0) & ~write_en_q;

endmodule
